// File: rtl/button_debounce_pulse.sv
// +--------------------------------------------------------------------------+
// | Module : button_debounce_pulse                                           |
// | Brief  : Synchronizes and debounces a raw push-button into a clean level |
// |          plus a one-cycle enable pulse per press, with optional repeat.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module button_debounce_pulse #(
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic button_i,
    output logic level_o,
    output logic enable_o
);

    localparam int C_MAX_CYCLES = (STABLE_CYCLES > REPEAT_CYCLES) ? STABLE_CYCLES : REPEAT_CYCLES;
    localparam int CW           = $clog2(C_MAX_CYCLES + 1);

    localparam logic [CW-1:0] C_CNT_ZERO    = '0;
    localparam logic [CW-1:0] C_CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] C_CNT_MAX     = '1;
    localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE_LOW  = 2'd0;
    localparam logic [1:0] S_WAIT_HIGH = 2'd1;
    localparam logic [1:0] S_IDLE_HIGH = 2'd2;
    localparam logic [1:0] S_WAIT_LOW  = 2'd3;

    logic          r_sync1;
    logic          r_btn_s;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_enable;
    logic          w_enable_nxt;
    logic          w_rep_en;
    logic          w_rep_fire;

    // The same counter times both debounce windows and the repeat period.
    generate
        if (REPEAT_CYCLES > 0) begin : g_repeat
            localparam logic [CW-1:0] C_REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
            assign w_rep_en   = 1'b1;
            assign w_rep_fire = (r_cnt == C_REPEAT_LAST);
        end else begin : g_no_repeat
            assign w_rep_en   = 1'b0;
            assign w_rep_fire = 1'b0;
        end
    endgenerate

    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_sync1  <= 1'b0;
            r_btn_s  <= 1'b0;
            r_state  <= S_IDLE_LOW;
            r_cnt    <= C_CNT_ZERO;
            r_level  <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_sync1  <= button_i;
            r_btn_s  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_level  <= w_level_nxt;
            r_enable <= w_enable_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_level_nxt  = r_level;
        w_enable_nxt = 1'b0;
        case (r_state)
            S_IDLE_LOW: begin
                if (r_btn_s) begin
                    w_state_nxt = S_WAIT_HIGH;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_IDLE_LOW;
                    w_cnt_nxt   = C_CNT_ZERO;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt  = S_IDLE_HIGH;
                    w_cnt_nxt    = C_CNT_ZERO;
                    w_level_nxt  = 1'b1;
                    w_enable_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_IDLE_HIGH: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_WAIT_LOW;
                    w_cnt_nxt   = C_CNT_ONE;
                end else if (w_rep_fire) begin
                    w_cnt_nxt    = C_CNT_ZERO;
                    w_enable_nxt = 1'b1;
                end else if (w_rep_en) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_LOW: begin
                // A bounce back high restarts the repeat period from zero.
                if (r_btn_s) begin
                    w_state_nxt = S_IDLE_HIGH;
                    w_cnt_nxt   = C_CNT_ZERO;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt = S_IDLE_LOW;
                    w_cnt_nxt   = C_CNT_ZERO;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE_LOW;
                w_cnt_nxt   = C_CNT_ZERO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign level_o  = r_level;
    assign enable_o = r_enable;

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_pulse.sv
// +--------------------------------------------------------------------------+
// | Module : tb_button_debounce_pulse                                        |
// | Brief  : Bench for button_debounce_pulse, no-repeat and repeat variants. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_button_debounce_pulse;

    localparam int STB = 4;
    localparam int REP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button = 1'b1;
    logic level_a, en_a, level_b, en_b;

    int vectors = 0;
    int miscompares = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    always #5 clk = ~clk;

    button_debounce_pulse #(.STABLE_CYCLES(STB), .REPEAT_CYCLES(0)) dut_a (
        .clock_i(clk), .reset_i(rst), .button_i(button), .level_o(level_a), .enable_o(en_a)
    );
    button_debounce_pulse #(.STABLE_CYCLES(STB), .REPEAT_CYCLES(REP)) dut_b (
        .clock_i(clk), .reset_i(rst), .button_i(button), .level_o(level_b), .enable_o(en_b)
    );

    // Reference: a level flips once the synchronized input has disagreed with it
    // for STB consecutive samples; while held high, a pulse every r held samples.
    typedef struct packed {
        logic lvl;
        logic en;
        int   run;
        int   held;
    } mstate_t;

    function automatic mstate_t mstep(mstate_t s, logic bs, int r);
        mstate_t n;
        n    = s;
        n.en = 1'b0;
        if (bs != s.lvl) begin
            n.run  = s.run + 1;
            n.held = 0;
            if (n.run == STB) begin
                n.lvl = bs;
                n.run = 0;
                n.en  = bs;
            end
        end else begin
            n.run = 0;
            if (s.lvl && r > 0) begin
                if (s.run != 0) n.held = 0;
                else if (s.held == r - 1) begin
                    n.held = 0;
                    n.en   = 1'b1;
                end else n.held = s.held + 1;
            end
        end
        return n;
    endfunction

    logic [1:0] hist = 2'b00;
    mstate_t ma = '0;
    mstate_t mb = '0;

    always @(posedge clk) begin
        if (rst) begin
            hist <= 2'b00;
            ma   <= '0;
            mb   <= '0;
        end else begin
            hist <= {hist[0], button};
            ma   <= mstep(ma, hist[1], 0);
            mb   <= mstep(mb, hist[1], REP);
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Checks outputs of the previous edge at the falling edge, then drives the next inputs.
    task automatic step(input logic b, input logic r);
        @(negedge clk);
        check("level_a", level_a, ma.lvl);
        check("enable_a", en_a, ma.en);
        check("level_b", level_b, mb.lvl);
        check("enable_b", en_b, mb.en);
        if (en_a === 1'b1) pulses_a++;
        if (en_b === 1'b1) pulses_b++;
        button = b;
        rst    = r;
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        int first;
        int len;
        logic lv;

        // Reset held three cycles with the button pressed
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("reset_level", level_a, 1'b0);
            check("reset_enable", en_b, 1'b0);
        end

        // Button held through reset release counts as one press
        pulses_a = 0; pulses_b = 0;
        hold(1'b1, 9);
        check_int("held_release_pulses_a", pulses_a, 1);
        check_int("held_release_pulses_b", pulses_b, 1);
        hold(1'b0, 9);
        check_int("release_no_pulse_a", pulses_a, 1);
        check("released_level", level_a, 1'b0);

        // Clean press latency: pulse visible after edge k+STB+1
        step(1'b1, 1'b0);
        first = 0;
        for (int j = 1; j <= 10; j++) begin
            step(1'b1, 1'b0);
            if (en_a === 1'b1 && first == 0) first = j;
        end
        check_int("press_latency", first, STB + 2);
        hold(1'b0, 10);

        // Bounce 1,0,1,1,0,1 then held
        pulses_a = 0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        hold(1'b1, 14);
        check_int("bounce_pulses", pulses_a, 1);
        hold(1'b0, 10);

        // Repeat while held 40 cycles, then release
        pulses_a = 0; pulses_b = 0;
        hold(1'b1, 40);
        hold(1'b0, 12);
        check_int("repeat_pulses_b", pulses_b, 5);
        check_int("norepeat_pulses_a", pulses_a, 1);

        // Glitches of STB-1 samples in both idle states
        pulses_a = 0;
        hold(1'b1, STB - 1);
        hold(1'b0, 10);
        check_int("glitch_high_pulses", pulses_a, 0);
        hold(1'b1, 10);
        hold(1'b0, STB - 1);
        hold(1'b1, 10);
        check("glitch_low_level", level_a, 1'b1);
        check_int("glitch_low_pulses", pulses_a, 1);
        hold(1'b0, 10);

        // Reset in the middle of a press window, button kept high
        pulses_a = 0;
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        check_int("midreset_no_pulse", pulses_a, 0);
        hold(1'b1, 12);
        check_int("midreset_one_pulse", pulses_a, 1);
        hold(1'b0, 10);

        // 17 clean presses wrap a 4-bit downstream counter to 1
        pulses_a = 0;
        for (int p = 0; p < 17; p++) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        check_int("counter_wrap", pulses_a % 16, 1);

        // Randomized run lengths with occasional reset
        lv = 1'b0;
        for (int k = 0; k < 120; k++) begin
            lv  = ~lv;
            len = (($urandom % 4) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) step(lv, ($urandom % 97) == 0);
        end
        hold(1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
